// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating direction
// counters. Lookup is combinational on if_pc. Training comes from the branch
// outcome that EX resolves.
// Optional feature macro: BTB_STATS_EN adds the branch/mispredict statistic
// counters and the ex_pre_right input.
module branch_target_buffer #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] if_pc,
    output logic [31:0] pc_pre,
    output logic        pred_hit,
    input  logic [31:0] ex_pc,
    input  logic        ex_branch,
    input  logic [31:0] ex_next_pc
`ifdef BTB_STATS_EN
    ,
    input  logic        ex_pre_right,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    logic                up_en, up_hit, taken;

    assign lk_idx = if_pc[IDX_BITS+1:2];
    assign lk_tag = if_pc[31:IDX_BITS+2];
    assign up_idx = ex_pc[IDX_BITS+1:2];
    assign up_tag = ex_pc[31:IDX_BITS+2];

    // Combinational lookup: only the counter MSB decides taken vs fall-through.
    always_comb begin
        pred_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pc_pre   = (pred_hit && ctr_q[lk_idx][1]) ? target_q[lk_idx] : if_pc + 32'd4;
    end

    // Training: a taken hit reinforces and refreshes the target, a not-taken
    // hit weakens, a taken miss allocates weak-taken (overwriting any alias).
    always_comb begin
        up_en    = ex_branch && !halt;
        taken    = (ex_next_pc != (ex_pc + 32'd4));
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (up_en) begin
            if (up_hit) begin
                if (taken) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    target_d[up_idx] = ex_next_pc;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = ex_next_pc;
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    // Table state; reset leaves every entry invalid and weak-not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Saturating counters of resolved branches and of mispredictions.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (up_en) begin
            if (stat_branches_q != 32'hFFFF_FFFF) stat_branches_d = stat_branches_q + 32'd1;
            if (!ex_pre_right && stat_mispredicts_q != 32'hFFFF_FFFF)
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Statistic registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a stimulus process drives one
// lookup/update per cycle and queues the expected lookup result computed from
// a table-level reference model; a monitor on the falling edge pops and checks.
module tb_branch_target_buffer;
    localparam int IDX = 4;
    localparam int N   = 1 << IDX;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] pc_pre;
    logic        pred_hit;
    logic [31:0] ex_pc = '0;
    logic        ex_branch = 1'b0;
    logic [31:0] ex_next_pc = '0;
`ifdef BTB_STATS_EN
    logic        ex_pre_right = 1'b1;
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_target_buffer #(.IDX_BITS(IDX)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .if_pc(if_pc), .pc_pre(pc_pre), .pred_hit(pred_hit),
        .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_next_pc(ex_next_pc)
`ifdef BTB_STATS_EN
        , .ex_pre_right(ex_pre_right), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pre;
        logic [31:0] nbr;
        logic [31:0] nmis;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-slot record; counter kept as an integer 0..3.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_nbr, m_nmis;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned tagof(input logic [31:0] pc);
        return int'(pc >> (IDX + 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = '0;
        end
        m_nbr = '0; m_nmis = '0;
    endtask

    function automatic exp_t model_lookup(input logic [31:0] pc);
        exp_t e;
        int s = slot(pc);
        e.pc   = pc;
        e.hit  = m_valid[s] && (m_tag[s] == tagof(pc));
        e.pre  = (e.hit && m_ctr[s] >= 2) ? m_tgt[s] : pc + 32'd4;
        e.nbr  = m_nbr;
        e.nmis = m_nmis;
        return e;
    endfunction

    task automatic model_train(input logic [31:0] epc, input logic [31:0] enp, input bit pr);
        int s = slot(epc);
        logic [31:0] fall = epc + 32'd4;
        bit tk = (enp != fall);
        bit hit = m_valid[s] && (m_tag[s] == tagof(epc));
        if (hit && tk) begin
            m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
            m_tgt[s] = enp;
        end else if (hit) begin
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end else if (tk) begin
            m_valid[s] = 1; m_tag[s] = tagof(epc); m_tgt[s] = enp; m_ctr[s] = 2;
        end
        if (m_nbr != 32'hFFFF_FFFF) m_nbr = m_nbr + 1;
        if (!pr && m_nmis != 32'hFFFF_FFFF) m_nmis = m_nmis + 1;
    endtask

    // One cycle: drive lookup + EX inputs, queue the expected lookup (old
    // table contents), then advance the model on the edge if it trains.
    task automatic step(input logic [31:0] ipc, input bit br, input logic [31:0] epc,
                        input logic [31:0] enp, input bit h, input bit pr);
        if_pc = ipc; ex_branch = br; ex_pc = epc; ex_next_pc = enp; halt = h;
`ifdef BTB_STATS_EN
        ex_pre_right = pr;
`endif
        exp_q.push_back(model_lookup(ipc));
        @(posedge clk);
        if (br && !h && !rst) model_train(epc, enp, pr);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic resolve(input logic [31:0] ipc, input logic [31:0] epc, input logic [31:0] enp);
        step(ipc, 1'b1, epc, enp, 1'b0, 1'b1);
    endtask

    // Monitor: the DUT output is settled at the falling edge of each cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (pred_hit !== e.hit) begin
                n_bad++;
                $display("FAIL pred_hit pc=%h got=%b exp=%b", e.pc, pred_hit, e.hit);
            end
            n_cmp++;
            if (pc_pre !== e.pre) begin
                n_bad++;
                $display("FAIL pc_pre pc=%h got=%h exp=%h", e.pc, pc_pre, e.pre);
            end
`ifdef BTB_STATS_EN
            n_cmp++;
            if (stat_branches !== e.nbr) begin
                n_bad++;
                $display("FAIL stat_branches got=%h exp=%h", stat_branches, e.nbr);
            end
            n_cmp++;
            if (stat_mispredicts !== e.nmis) begin
                n_bad++;
                $display("FAIL stat_mispredicts got=%h exp=%h", stat_mispredicts, e.nmis);
            end
`endif
        end
    end

    initial begin
        logic [31:0] tags [4];
        model_reset();
        tags[0] = 32'h0000_0000; tags[1] = 32'h0000_0040;
        tags[2] = 32'h1234_5680; tags[3] = 32'hFFFF_FFC0;
        @(posedge clk); #1;
        // Held in reset: empty table, sequential fall-through with wrap.
        look(32'h0000_0000);
        look(32'h0000_003C);
        look(32'hFFFF_FFFC);
        rst = 1'b0;
        // Allocate; same-cycle lookup still sees the old (empty) slot.
        resolve(32'h100, 32'h100, 32'h200);
        look(32'h100);
        // Counter walk: 10 -> 01 -> 10 -> 11 -> 11 (sat) -> 10.
        resolve(32'h100, 32'h100, 32'h104);
        look(32'h100);
        resolve(32'h100, 32'h100, 32'h200);
        resolve(32'h100, 32'h100, 32'h200);
        resolve(32'h100, 32'h100, 32'h200);
        resolve(32'h100, 32'h100, 32'h200);
        resolve(32'h100, 32'h100, 32'h104);
        look(32'h100);
        // Alias on the same slot replaces 0x100; not-taken alias does nothing.
        resolve(32'h140, 32'h140, 32'h500);
        look(32'h140);
        look(32'h100);
        resolve(32'h140, 32'h180, 32'h184);
        look(32'h140);
        // Halt blocks allocation.
        step(32'h300, 1'b1, 32'h300, 32'h600, 1'b1, 1'b0);
        look(32'h300);
        // Async reset between edges clears the hit immediately.
        look(32'h140);
        if_pc = 32'h140; ex_branch = 1'b0; halt = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        exp_q.push_back(model_lookup(32'h140));
        @(posedge clk); #1;
        rst = 1'b0;
        look(32'h140);
`ifdef BTB_STATS_EN
        // Five branches, three reported wrong.
        step(32'h0, 1'b1, 32'h400, 32'h404, 1'b0, 1'b1);
        step(32'h0, 1'b1, 32'h400, 32'h800, 1'b0, 1'b0);
        step(32'h0, 1'b1, 32'h400, 32'h800, 1'b0, 1'b1);
        step(32'h0, 1'b1, 32'h400, 32'h404, 1'b0, 1'b0);
        step(32'h0, 1'b1, 32'h400, 32'h404, 1'b0, 1'b0);
        look(32'h400);
        // Preload both counters at the ceiling and confirm they hold there.
        @(negedge clk);
        force dut.stat_branches_q = 32'hFFFF_FFFF;
        force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branches_q;
        release dut.stat_mispredicts_q;
        m_nbr = 32'hFFFF_FFFF; m_nmis = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        step(32'h0, 1'b1, 32'h400, 32'h900, 1'b0, 1'b0);
        look(32'h0);
`endif
        // Randomized traffic over a few tags so slots collide often.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ip, ep, np;
            bit br, h, pr;
            ip = tags[$urandom_range(0, 3)] | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            ep = tags[$urandom_range(0, 3)] | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            np = ($urandom_range(0, 2) == 0) ? ep + 32'd4 : {$urandom_range(0, 7), 2'b00} * 32'h100;
            br = ($urandom_range(0, 3) != 0);
            h  = ($urandom_range(0, 9) == 0);
            pr = $urandom_range(0, 1);
            step(ip, br, ep, np, h, pr);
        end
        ex_branch = 1'b0;
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Dynamic branch predictor for the five-stage pipeline: a direct-mapped branch target buffer with 2-bit saturating direction counters. It sits beside IF and produces the predicted next fetch PC (`pc_pre`) that travels down the pipe to EX. It is trained every cycle from the resolved branch outcome that EX reports (`branch`, `next_pc`). It sequences the fetch stream; on a misprediction, EX asserts `jump_rst` and flushes, and this block learns from the same event.

## Interface
- `IDX_BITS`, 4: index width; table holds 2^IDX_BITS entries.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `halt`  in  1  freezes all table and statistic updates while high.
- `if_pc`  in  32  current fetch PC.
- `pc_pre`  out  32  predicted next fetch PC for `if_pc`.
- `pred_hit`  out  1  lookup hit a valid entry with a matching tag.
- `ex_pc`  in  32  PC of the instruction in EX.
- `ex_branch`  in  1  EX instruction is j/jr/jal/beq/bne/blez.
- `ex_next_pc`  in  32  resolved next PC from EX.
- `stat_branches`  out  32  resolved branch count (`BTB_STATS_EN` only).
- `stat_mispredicts`  out  32  mispredicted branch count (`BTB_STATS_EN` only).
- `ex_pre_right`  in  1  EX reports `pc_pre == next_pc` (`BTB_STATS_EN` only).

## Operation
- Entry fields: `valid`, `tag[31-IDX_BITS-2:0]`, `target[31:0]`, `ctr[1:0]`.
- Index is `pc[IDX_BITS+1:2]`. Tag is `pc[31:IDX_BITS+2]`. `pc[1:0]` is ignored.
- Lookup (combinational): `pred_hit = valid[idx] & (tag[idx] == if_pc tag)`.
- `pc_pre = (pred_hit & ctr[idx][1]) ? target[idx] : if_pc + 4`. The addition wraps modulo 2^32.
- Actual-taken: `taken = (ex_next_pc != ex_pc + 4)`. Computed internally with a 32-bit wrapping add.
- Update happens on a rising edge with `ex_branch & ~halt`. Entry is selected by `ex_pc`.
  - Tag hit, taken: `ctr` increments, saturating at 2'b11; `target <= ex_next_pc`.
  - Tag hit, not taken: `ctr` decrements, saturating at 2'b00; `target` is unchanged.
  - Miss (invalid entry or tag mismatch), taken: allocate. Set `valid=1`, `tag`, `target=ex_next_pc`, `ctr=2'b10`. A conflicting entry is overwritten.
  - Miss, not taken: no change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Only `ctr[1]` drives prediction.
- With `ex_branch=0` or `halt=1`, the table holds.

## Timing
- Lookup has zero latency: `pc_pre`/`pred_hit` follow `if_pc` combinationally.
- Update latency is one edge. A lookup in the same cycle as an update to the same index sees the old contents; the new contents are visible from the next cycle.
- Reset: all `valid=0` and all `ctr=2'b01`; targets and tags are don't-care.
- Outputs during and after reset: `pred_hit=0`, `pc_pre=if_pc+4`, statistics 0.
- Reset asserted mid-operation clears state immediately, regardless of `clk` or `halt`. The first update is the first edge after `rst` falls.
- `halt` and `ex_branch` in the same cycle: no update.

## Configuration
- `BTB_STATS_EN` defined: `stat_branches` and `stat_mispredicts` exist, along with the `ex_pre_right` input.
  - Both statistics are 32-bit counters that saturate at 0xFFFFFFFF.
  - On each `ex_branch & ~halt` edge, `stat_branches` increments.
  - On the same edge, `stat_mispredicts` also increments if `ex_pre_right=0`.
- `BTB_STATS_EN` undefined: these ports and counters are absent. Prediction behaviour is identical in both cases.

## Test plan
- Reset, then sweep `if_pc` over 0x0, 0x3C, 0xFFFFFFFC -> `pred_hit=0`; `pc_pre` = 0x4, 0x40, 0x0 (wrap).
- Taken beq at 0x100 with `ex_next_pc=0x200`, then `if_pc=0x100` -> `pred_hit=1`, `pc_pre=0x200`. A same-cycle lookup during the update still returns 0x104.
- Same branch resolves not-taken (`ex_next_pc=0x104`) once -> ctr 01, `pc_pre=0x104`. Three taken resolutions -> ctr 11. A fourth taken leaves ctr at 11. Then one not-taken -> 10, still predicts 0x200.
- Alias: 0x100 allocated, then taken branch at 0x140 (same index for IDX_BITS=4) -> 0x140 hits; lookup at 0x100 misses, `pc_pre=0x104`. A not-taken branch at 0x180 leaves the 0x140 entry intact.
- `halt=1` with `ex_branch=1` taken at 0x300 -> no allocation. Reset pulsed asynchronously between edges -> `pred_hit` drops to 0 immediately.
- `BTB_STATS_EN`: five branches with `ex_pre_right` = 1,0,1,0,0 -> `stat_branches=5`, `stat_mispredicts=3`. Preloading by forcing 0xFFFFFFFF holds at saturation.
